// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-lane data memory.
// Size codes, FSM states, lane-mask helper and response bundle.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      (size == SZ_B): m = 4'b0001 << lane;
      (size == SZ_H): m = lane[1] ? 4'b1100 : 4'b0011;
      (size == SZ_W): m = 4'b1111;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load extraction/extension and store-data lane replication.
// Ports: size, lane, sgn, rword, wdata in; rdata, wrep out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] wrep
);

  logic [31:0] bsh;
  logic [31:0] hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = rword >> {lane, 3'b000};
  assign hsh = rword >> {lane[1], 4'b0000};
  assign b   = bsh[7:0];
  assign h   = hsh[15:0];

  always_comb begin
    rdata = rword;
    wrep  = wdata;
    unique case (1'b1)
      (size == SZ_B): begin
        rdata = {{24{sgn & b[7]}}, b};
        wrep  = {4{wdata[7:0]}};
      end
      (size == SZ_H): begin
        rdata = {{16{sgn & h[15]}}, h};
        wrep  = {2{wdata[15:0]}};
      end
      default: begin
        rdata = rword;
        wrep  = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed 32-bit data memory with post-reset clear sequencer.
// Ports: clk, rst_n, req_* (valid/ready request), rsp_* (1-cycle response), busy.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int WORDS      = 256,
  parameter bit INIT_CLEAR = 1'b1,
  parameter int ADDR_W     = $clog2(WORDS) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = ADDR_W - 2;

  logic [0:0]    state;
  logic [IW-1:0] cnt;
  logic [31:0]   mem [WORDS];
  rsp_t          rsp;

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          accept;
  logic          err;
  logic [31:0]   ld;
  logic [31:0]   wrep;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;

  assign idx  = req_addr[ADDR_W-1:2];
  assign lane = req_addr[1:0];

  // rst_n gates ready so nothing is accepted while reset is held
  assign req_ready = rst_n & (state == ST_IDLE);
  assign busy      = (state == ST_INIT);
  assign accept    = req_valid & req_ready;

  assign err = (req_size == 2'b11)
             | ((req_size == SZ_H) & lane[0])
             | ((req_size == SZ_W) & (lane != 2'b00));

  dmem_lane_align u_align (
    .size  (req_size),
    .lane  (lane),
    .sgn   (req_signed),
    .rword (mem[idx]),
    .wdata (req_wdata),
    .rdata (ld),
    .wrep  (wrep)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_mask = lane_mask(req_size, lane);
    wr_data = wrep;
    if (state == ST_INIT) begin
      wr_en   = rst_n;
      wr_idx  = cnt;
      wr_mask = 4'b1111;
      wr_data = '0;
    end else begin
      wr_en = accept & req_we & ~err;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CLEAR ? ST_INIT : ST_IDLE;
      cnt   <= '0;
      rsp   <= '0;
    end else begin
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IW'(WORDS - 1)) state <= ST_IDLE;
      end
      rsp.valid <= accept;
      rsp.err   <= accept & err;
      rsp.rdata <= (accept & ~req_we & ~err) ? ld : '0;
    end
  end

  assign rsp_valid = rsp.valid;
  assign rsp_err   = rsp.err;
  assign rsp_rdata = rsp.rdata;

endmodule
